bus_wait_ctrl: RTL



---
 rtl/bus_wait_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/bus_wait_ctrl.sv
// rtl/bus_wait_ctrl.sv - 6309E bus wait-state controller with V9958 recovery gap and wait-line follow
module bus_wait_ctrl #(
  parameter int RAM_WAITS   = 0,
  parameter int ROM_WAITS   = 1,
  parameter int IO_WAITS    = 1,
  parameter int VDP_WAITS   = 2,
  parameter int VDP_GAP     = 24,
  parameter int VDP_TIMEOUT = 255
) (
  input  logic       MHZ12,
  input  logic       RESET,
  input  logic       nQ,
  input  logic [1:0] REGION,
  input  logic       nVDPWAIT,
  input  logic       CFG_WE,
  input  logic [7:0] CFG_DATA,
  output logic       nWAIT,
  output logic       BUSY,
  output logic       TIMEOUT
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GAP   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_VHOLD = 2'd3;

  localparam logic [7:0] GAP_MIN   = 8'(VDP_GAP);
  localparam logic [7:0] TMO_LAST  = 8'(VDP_TIMEOUT - 1);
  localparam logic [7:0] WAITS_RST = {2'(VDP_WAITS), 2'(IO_WAITS), 2'(ROM_WAITS), 2'(RAM_WAITS)};

  logic [1:0] r_state, w_state_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic [7:0] r_tcnt, w_tcnt_nx;
  logic [1:0] r_w_vdp, w_w_vdp_nx;
  logic       r_is_vdp, w_is_vdp_nx;
  logic [7:0] r_gap_cnt;
  logic [7:0] r_waits;
  logic       r_nq_d, r_vw_meta, r_vw_s;
  logic       r_nwait, r_busy, r_timeout;
  logic       w_start, w_gap_short, w_timeout_fire, w_vdp_done;
  logic [1:0] w_wsel;

  assign w_start     = r_nq_d & ~nQ;
  assign w_gap_short = (r_gap_cnt < GAP_MIN);

  always_comb begin
    w_wsel = r_waits[1:0];
    case (REGION)
      2'd1:    w_wsel = r_waits[3:2];
      2'd2:    w_wsel = r_waits[5:4];
      2'd3:    w_wsel = r_waits[7:6];
      default: w_wsel = r_waits[1:0];
    endcase
  end

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_tcnt_nx      = r_tcnt;
    w_w_vdp_nx     = r_w_vdp;
    w_is_vdp_nx    = r_is_vdp;
    w_timeout_fire = 1'b0;
    w_vdp_done     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          // Wait count is frozen here so a later CFG_WE cannot alter this access
          w_is_vdp_nx = (REGION == 2'd3);
          w_w_vdp_nx  = w_wsel;
          w_cnt_nx    = {w_wsel, 1'b0};
          w_tcnt_nx   = 8'd0;
          if (REGION == 2'd3) begin
            if (w_gap_short)          w_state_nx = S_GAP;
            else if (w_wsel != 2'd0)  w_state_nx = S_COUNT;
            else                      w_state_nx = S_VHOLD;
          end else if (w_wsel != 2'd0) begin
            w_state_nx = S_COUNT;
          end
        end
      end
      S_GAP: begin
        if (!w_gap_short) begin
          w_cnt_nx   = {r_w_vdp, 1'b0};
          w_tcnt_nx  = 8'd0;
          w_state_nx = (r_w_vdp != 2'd0) ? S_COUNT : S_VHOLD;
        end
      end
      S_COUNT: begin
        w_cnt_nx = r_cnt - 3'd1;
        if (r_cnt == 3'd1) begin
          w_tcnt_nx  = 8'd0;
          w_state_nx = r_is_vdp ? S_VHOLD : S_IDLE;
        end
      end
      S_VHOLD: begin
        if (r_vw_s) begin
          w_state_nx = S_IDLE;
          w_vdp_done = 1'b1;
        end else if (r_tcnt == TMO_LAST) begin
          w_state_nx     = S_IDLE;
          w_vdp_done     = 1'b1;
          w_timeout_fire = 1'b1;
        end else begin
          w_tcnt_nx = r_tcnt + 8'd1;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge MHZ12) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= 3'd0;
      r_tcnt    <= 8'd0;
      r_w_vdp   <= 2'd0;
      r_is_vdp  <= 1'b0;
      r_gap_cnt <= 8'hFF;
      r_waits   <= WAITS_RST;
      r_nq_d    <= 1'b0;
      r_vw_meta <= 1'b1;
      r_vw_s    <= 1'b1;
      r_nwait   <= 1'b1;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_tcnt    <= w_tcnt_nx;
      r_w_vdp   <= w_w_vdp_nx;
      r_is_vdp  <= w_is_vdp_nx;
      r_nq_d    <= nQ;
      r_vw_meta <= nVDPWAIT;
      r_vw_s    <= r_vw_meta;
      r_nwait   <= (w_state_nx == S_IDLE);
      r_busy    <= (w_state_nx != S_IDLE);
      if (CFG_WE) r_waits <= CFG_DATA;
      if (w_timeout_fire)  r_timeout <= 1'b1;
      else if (CFG_WE)     r_timeout <= 1'b0;
      // Recovery gap is measured from the cycle a VDP access leaves the bus
      if (w_vdp_done)                r_gap_cnt <= 8'd0;
      else if (r_gap_cnt != 8'hFF)   r_gap_cnt <= r_gap_cnt + 8'd1;
    end
  end

  assign nWAIT   = r_nwait;
  assign BUSY    = r_busy;
  assign TIMEOUT = r_timeout;

endmodule
